muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit. Sits downstream of register_file:
//  consumes the rs1/rs2 read values (rd1/rd2) plus funct3 and the destination
//  index, and returns result/rd/write_enable for the register_file write port.
//  Shift-add multiply and restoring divide: one bit per cycle, no DSP inference.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clock         in   1     single clock, all state updates on posedge
//  reset_n       in   1     synchronous reset, active-low
//  start         in   1     request; accepted only while ready=1
//  funct3        in   3     RV32M op: 000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                           100 DIV,101 DIVU,110 REM,111 REMU
//  op_a          in   XLEN  rs1 value (register_file rd1)
//  op_b          in   XLEN  rs2 value (register_file rd2)
//  rd_in         in   5     destination register index
//  kill          in   1     abort in-flight op (pipeline flush)
//  ready         out  1     1 in IDLE only
//  result_valid  out  1     1-cycle pulse, result/rd_out valid
//  result        out  XLEN  final value; held until next accepted op
//  rd_out        out  5     latched rd_in of the completing op
//  write_enable  out  1     result_valid & (rd_out != 0); x0 never written
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state IDLE, ready=1, result_valid=0,
//    write_enable=0, result=0, rd_out=0, counter=0. Mid-op reset discards op.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: start=1 latches funct3/rd_in and magnitudes |op_a|,|op_b| (signed
//    ops only; MULHSU treats op_b unsigned), records result sign, clears acc,
//    counter=0 -> BUSY. Special divide cases bypass BUSY -> DONE directly.
//    BUSY: one iteration per cycle; counter++; at counter==XLEN-1 -> DONE.
//    DONE: result_valid=1, sign fix-up applied, -> IDLE. ready=0 here.
//  - Latency: normal op accepted at cycle 0 -> result_valid at cycle XLEN+1
//    (33). Special divide cases -> result_valid at cycle 1.
//  - start while ready=0 is ignored (no queueing); caller must hold/retry.
//  - kill: in BUSY or DONE -> IDLE next cycle, result_valid suppressed,
//    result/rd_out unchanged. kill in IDLE ignored; kill beats start same cycle.
//  - Multiply: 2*XLEN-bit unsigned product of magnitudes, negated if sign set.
//    MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits.
//  - Divide: restoring, quotient/remainder of magnitudes. Quotient sign =
//    sign(a)^sign(b); remainder sign = sign(a) (DIV/REM only).
//  - Divide by zero: DIV/DIVU = all ones; REM/REMU = op_a unchanged.
//  - Signed overflow (op_a=0x80000000, op_b=-1): DIV = 0x80000000, REM = 0.
//  - Sign handling: magnitude of 0x80000000 is 0x80000000 in XLEN-bit unsigned;
//    no extra width needed for operands, 2*XLEN for multiply accumulator.
// STRUCTURE
//  - Shared package (riscv_pkg): funct3 M-extension constants, FSM state
//    encoding localparams, XLEN default.
//  - Single module; no sub-module — shared accumulator/shift register serves
//    both mul and div, selected by funct3[2].
// TESTING
//  - MUL 7 * -3 (0xFFFFFFFD), rd=5 -> cycle 33 result=0xFFFFFFEB, rd_out=5,
//    write_enable=1, result_valid one cycle only.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF
//    -> 0xFFFFFFFE; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV 7/0 -> 0xFFFFFFFF at cycle 1; REMU 7/0 -> 7; DIV 0x80000000/-1 ->
//    0x80000000; REM same -> 0; DIV -7/2 -> -3, REM -7/2 -> -1.
//  - start pulsed at cycles 0 and 5 -> only first op executes, ready=0 cycles
//    1..33, single result_valid at 33.
//  - reset_n=0 at cycle 10 of DIVU -> next cycle ready=1, result=0,
//    result_valid never asserted; kill at cycle 10 -> same, result unchanged.
//  - rd_in=0 with MUL 2*3 -> result=6, result_valid=1, write_enable=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   XLEN_DEF       default operand/result width
//   F3_*           M-extension funct3 encodings
//   state_t        FSM state encoding (IDLE -> BUSY -> DONE)
//   a_is_signed()  rs1 is treated as two's complement for this op
//   b_is_signed()  rs2 is treated as two's complement for this op
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_BUSY_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_BUSY = ST_BUSY_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
           (f == F3_DIV) || (f == F3_REM);
  endfunction

  // MULHSU reads rs2 as unsigned, so it is excluded here.
  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
//   clock, reset_n        clock and synchronous active-low reset
//   start, funct3         request (taken only while ready) and M-extension op
//   op_a, op_b, rd_in     rs1/rs2 values and destination register index
//   kill                  abandon the op in flight (pipeline flush)
//   ready                 unit is idle and will accept start
//   result_valid          one-cycle completion pulse
//   result, rd_out        completed value and destination (held until replaced)
//   write_enable          register_file write strobe, never for x0
// A single 2*XLEN accumulator is shared: shift-add multiply shifts right,
// restoring divide shifts left; funct3[2] picks which step is applied.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            ready,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            write_enable
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op;
  logic [4:0]        rd_pend;
  logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;
  logic              neg_main;   // negate product / quotient
  logic              neg_rem;    // negate remainder
  logic [CW-1:0]     count;
  logic              valid;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   prev_result;
  logic [4:0]        prev_rd;

  // Operand conditioning at acceptance
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_val;

  always_comb begin
    sign_a   = a_is_signed(funct3) & op_a[XLEN-1];
    sign_b   = b_is_signed(funct3) & op_b[XLEN-1];
    // -MIN_NEG wraps back to MIN_NEG, which is the correct unsigned magnitude.
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    if (div_zero) special_val = funct3[1] ? op_a : '1;
    else          special_val = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of the shared datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_val;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder shifted left by one needs a carry bit before the trial subtract.
    rem_shift = acc[2*XLEN-1:XLEN-1];
    rem_diff  = rem_shift - {1'b0, opnd};
    rem_ge    = rem_shift >= {1'b0, opnd};
    if (op[2])
      step = {(rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
              acc[XLEN-2:0], rem_ge};
    else
      step = {mul_sum, acc[XLEN-1:1]};

    prod = neg_main ? -step : step;
    quo  = neg_main ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem  = neg_rem ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:          final_val = prod[XLEN-1:0];
      F3_DIV, F3_DIVU: final_val = quo;
      F3_REM, F3_REMU: final_val = rem;
      default:         final_val = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op          <= '0;
      rd_pend     <= '0;
      opnd        <= '0;
      acc         <= '0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      count       <= '0;
      valid       <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      prev_result <= '0;
      prev_rd     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // kill wins over a same-cycle start
          if (start && !kill) begin
            op       <= funct3;
            rd_pend  <= rd_in;
            opnd     <= mag_b;
            acc      <= {{XLEN{1'b0}}, mag_a};
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            count    <= '0;
            if (div_zero || div_ovf) begin
              prev_result <= result_q;
              prev_rd     <= rd_q;
              result_q    <= special_val;
              rd_q        <= rd_in;
              valid       <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            acc   <= step;
            count <= count + CW'(1);
            if (count == CW'(XLEN-1)) begin
              prev_result <= result_q;
              prev_rd     <= rd_q;
              result_q    <= final_val;
              rd_q        <= rd_pend;
              valid       <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        default: begin
          // A kill landing on the completion cycle retracts the update.
          if (kill) begin
            result_q <= prev_result;
            rd_q     <= prev_rd;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready        = (state == ST_IDLE);
  assign result_valid = valid & ~kill;
  assign result       = result_q;
  assign rd_out       = rd_q;
  assign write_enable = result_valid & (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        ready;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        write_enable;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_result;
  logic [4:0]  last_rd;

  muldiv_unit #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill),
    .ready(ready), .result_valid(result_valid), .result(result),
    .rd_out(rd_out), .write_enable(write_enable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics via 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int q;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp_res;
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    logic        got_we;
    int lat, exp_lat, pulses;
    exp_res = ref_result(f, a, b);
    exp_lat = is_special(f, a, b) ? 1 : 33;
    got_res = '0; got_rd = '0; got_we = 1'b0;
    @(negedge clock);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; pulses = 0;
    // Each pass observes cycle j (the interval ending at edge j).
    for (int j = 1; j <= 40; j++) begin
      if (result_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = j; got_res = result; got_rd = rd_out; got_we = write_enable;
        end
      end
      @(posedge clock); #1;
    end
    $display("[TB] %s f3=%0d a=%h b=%h rd=%0d -> res=%h lat=%0d", tag, f, a, b, rd, got_res, lat);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".result"}, got_res, exp_res);
    check({tag, ".rd_out"}, got_rd, rd);
    check({tag, ".we"}, got_we, rd != 0);
    check({tag, ".held"}, result, exp_res);
    last_result = exp_res;
    last_rd     = rd;
  endtask

  // Start a long DIVU, then hit it at cycle 10 with reset or kill.
  task automatic abort_op(input bit use_reset, input string tag);
    int pulses;
    @(negedge clock);
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    pulses = 0;
    for (int j = 1; j <= 45; j++) begin
      if (result_valid) pulses++;
      if (j == 10) begin
        if (use_reset) reset_n = 1'b0; else kill = 1'b1;
      end
      if (j == 11) begin
        reset_n = 1'b1; kill = 1'b0;
        check({tag, ".ready"}, ready, 1'b1);
        check({tag, ".result"}, result, use_reset ? 32'h0 : last_result);
        check({tag, ".rd_out"}, rd_out, use_reset ? 5'd0 : last_rd);
      end
      @(posedge clock); #1;
    end
    $display("[TB] %s abort at cycle 10, pulses=%0d", tag, pulses);
    check({tag, ".no_valid"}, pulses, 0);
    if (use_reset) begin
      last_result = '0; last_rd = '0;
    end
  endtask

  initial begin
    int ready_low, pulses, lat;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.ready", ready, 1'b1);
    check("rst.valid", result_valid, 1'b0);
    check("rst.we", write_enable, 1'b0);
    check("rst.result", result, 32'h0);
    check("rst.rd_out", rd_out, 5'd0);
    reset_n = 1'b1;
    last_result = '0; last_rd = '0;

    // Directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7x-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu");
    run_op(3'd4, 32'd7, 32'd0, 5'd4, "div_by0");
    run_op(3'd7, 32'd7, 32'd0, 5'd6, "remu_by0");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd6, "rem_neg_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "rem_ovf");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, "rem_-7/2");
    run_op(3'd0, 32'd2, 32'd3, 5'd0, "mul_x0");

    // start at cycles 0 and 5: only the first is taken
    @(negedge clock);
    funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ready_low = 0; pulses = 0; lat = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j <= 33 && !ready) ready_low++;
      if (j == 34) check("b2b.ready_back", ready, 1'b1);
      if (result_valid) begin
        pulses++;
        if (lat == 0) lat = j;
      end
      if (j == 5) begin
        funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd12; start = 1'b1;
      end
      if (j == 6) start = 1'b0;
      @(posedge clock); #1;
    end
    $display("[TB] b2b start@0,5 ready_low=%0d pulses=%0d lat=%0d res=%h", ready_low, pulses, lat, result);
    check("b2b.ready_low", ready_low, 33);
    check("b2b.pulses", pulses, 1);
    check("b2b.lat", lat, 33);
    check("b2b.result", result, 32'hFFFF_FFEB);
    check("b2b.rd_out", rd_out, 5'd5);
    last_result = 32'hFFFF_FFEB; last_rd = 5'd5;

    abort_op(1'b1, "reset_mid");
    run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd13, "mulh_prep");
    abort_op(1'b0, "kill_mid");

    // kill and start together in IDLE: start must be dropped
    @(negedge clock);
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd14; start = 1'b1; kill = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; kill = 1'b0;
    pulses = 0;
    for (int j = 1; j <= 40; j++) begin
      if (result_valid) pulses++;
      @(posedge clock); #1;
    end
    $display("[TB] kill+start in idle pulses=%0d res=%h", pulses, result);
    check("killstart.pulses", pulses, 0);
    check("killstart.result", result, last_result);

    // Randomized ops including the divide corner cases
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 100)); rb = 32'($urandom_range(1, 9)); end
        3: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(rf, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
